// File: rtl/bcd_conv_sched_pkg.sv
// bcd_conv_sched_pkg: FSM state encoding and BCD double-dabble constants
package bcd_conv_sched_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_e;
  localparam int BCD_W = 16;
  localparam logic [3:0] NIB_THR = 4'd4;
  localparam logic [3:0] NIB_ADD = 4'd3;
endpackage

// File: rtl/bcd_conv_sched_if.sv
// bcd_conv_sched_if: requester bus (req/bin_in in; ack/busy/done/done_ch/bcd_out out), master = requesters, slave = converter
interface bcd_conv_sched_if #(parameter int NCH = 4, parameter int W = 12);
  logic [NCH-1:0] req;
  logic [NCH*W-1:0] bin_in;
  logic [NCH-1:0] ack;
  logic busy;
  logic done;
  logic [2:0] done_ch;
  logic [NCH*16-1:0] bcd_out;
  modport master(output req, bin_in, input ack, busy, done, done_ch, bcd_out);
  modport slave(input req, bin_in, output ack, busy, done, done_ch, bcd_out);
endinterface

// File: rtl/bcd_shift_core.sv
// bcd_shift_core: double-dabble datapath (load captures bin, step does one add-3/shift, bcd is the accumulator, last flags the final step)
module bcd_shift_core
  import bcd_conv_sched_pkg::*;
#(
  parameter int W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [W-1:0]     bin,
  input  logic             step,
  output logic [BCD_W-1:0] bcd,
  output logic             last
);
  localparam int CW = $clog2(W);
  logic [BCD_W-1:0] acc_q, adj;
  logic [W-1:0] bin_q;
  logic [CW-1:0] cnt_q;
  always_comb begin
    adj = '0;
    for (int n = 0; n < BCD_W / 4; n++)
      adj[n*4 +: 4] = acc_q[n*4 +: 4] > NIB_THR ? acc_q[n*4 +: 4] + NIB_ADD : acc_q[n*4 +: 4];
  end
  always_ff @(posedge clk)
    if (rst) begin
      acc_q <= '0;
      bin_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      acc_q <= '0;
      bin_q <= bin;
      cnt_q <= '0;
    end else if (step) begin
      acc_q <= {adj[BCD_W-2:0], bin_q[W-1]};
      bin_q <= bin_q << 1;
      cnt_q <= cnt_q + 1'b1;
    end
  assign bcd = acc_q;
  assign last = cnt_q == CW'(W - 1);
endmodule

// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched: round-robin scheduler sharing one binary-to-BCD converter across NCH channels (clk_100M, rst, bus slave)
module bcd_conv_sched
  import bcd_conv_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 12
) (
  input logic           clk_100M,
  input logic           rst,
  bcd_conv_sched_if.slave bus
);
  state_e state_q;
  logic [2:0] ptr_q, gnt_q, gnt_d, done_ch_q;
  logic [NCH-1:0] ack_q;
  logic busy_q, done_q, core_last;
  logic [NCH*BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] core_bcd;
  always_comb begin
    gnt_d = ptr_q;
    for (int i = NCH - 1; i >= 0; i--)
      if (bus.req[(int'(ptr_q) + i) % NCH]) gnt_d = 3'((int'(ptr_q) + i) % NCH);
  end
  bcd_shift_core #(.W(W)) u_core (
    .clk  (clk_100M),
    .rst  (rst),
    .load (state_q == LOAD),
    .bin  (bus.bin_in[gnt_q*W +: W]),
    .step (state_q == SHIFT),
    .bcd  (core_bcd),
    .last (core_last)
  );
  always_ff @(posedge clk_100M)
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_ch_q <= '0;
      bcd_q     <= '0;
    end else begin
      ack_q  <= '0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (|bus.req) begin
          gnt_q   <= gnt_d;
          ack_q   <= NCH'(1) << gnt_d;
          busy_q  <= 1'b1;
          state_q <= LOAD;
        end
        LOAD: state_q <= SHIFT;
        SHIFT: if (core_last) state_q <= STORE;
        STORE: begin
          bcd_q[gnt_q*BCD_W +: BCD_W] <= core_bcd;
          done_q    <= 1'b1;
          done_ch_q <= gnt_q;
          ptr_q     <= gnt_q == 3'(NCH - 1) ? 3'd0 : gnt_q + 3'd1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  assign bus.ack     = ack_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.done_ch = done_ch_q;
  assign bus.bcd_out = bcd_q;
endmodule

// File: tb/tb_bcd_conv_sched.sv
// tb_bcd_conv_sched: directed and random checks of the round-robin BCD converter
module tb_bcd_conv_sched;
  localparam int NCH = 4;
  localparam int W = 12;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  int n;
  logic [15:0] exp_slot [NCH];
  bcd_conv_sched_if #(.NCH(NCH), .W(W)) bus();
  bcd_conv_sched #(.NCH(NCH), .W(W)) dut (.clk_100M(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] ref_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction
  always @(negedge clk) if (!rst) check("ack_onehot", 32'($onehot0(bus.ack)), 1);
  task automatic check_slots;
    for (int k = 0; k < NCH; k++) check($sformatf("slot%0d", k), bus.bcd_out[k*16 +: 16], exp_slot[k]);
  endtask
  task automatic convert(input int ch, input logic [11:0] v, input logic [15:0] exp, input bit corrupt);
    int c;
    bus.bin_in[ch*W +: W] = v;
    bus.req = NCH'(1) << ch;
    c = 0;
    do begin @(negedge clk); c++; end while (bus.ack == '0 && c < 10);
    check("ack", bus.ack, 32'(1) << ch);
    check("busy_hi", bus.busy, 1);
    bus.req = '0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
      if (c == 1 && corrupt) begin
        bus.bin_in[ch*W +: W] = ~v;
        bus.req = NCH'(1) << ch;
      end
    end while (!bus.done && c < 40);
    bus.req = '0;
    check("latency", c, 14);
    check("done_ch", bus.done_ch, ch);
    check("busy_lo", bus.busy, 0);
    exp_slot[ch] = exp;
    check_slots();
    @(negedge clk);
    check("done_pulse", bus.done, 0);
    if (corrupt) begin
      do begin @(negedge clk); c++; end while (!bus.done && c < 80);
      @(negedge clk);
    end
  endtask
  initial begin
    bus.req = '0;
    bus.bin_in = '0;
    for (int k = 0; k < NCH; k++) exp_slot[k] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_done_ch", bus.done_ch, 0);
    check_slots();
    convert(0, 12'd4095, 16'h4095, 1'b0);
    convert(1, 12'd0, 16'h0000, 1'b0);
    convert(2, 12'd1234, 16'h1234, 1'b0);
    convert(3, 12'd999, 16'h0999, 1'b0);
    bus.bin_in = {12'd4000, 12'd605, 12'd80, 12'd7};
    bus.req = '1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.done && n < 40);
      check("rr_ch", bus.done_ch, k % 4);
      if (k > 0) check("rr_gap", n, 15);
    end
    bus.req = '0;
    exp_slot[0] = 16'h0007;
    exp_slot[1] = 16'h0080;
    exp_slot[2] = 16'h0605;
    exp_slot[3] = 16'h4000;
    check_slots();
    @(negedge clk);
    check("rr_idle", bus.busy, 0);
    convert(1, 12'd321, 16'h0321, 1'b1);
    bus.bin_in[2*W +: W] = 12'd777;
    bus.req = 4'b0100;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.ack == '0 && n < 10);
    check("abort_ack", bus.ack, 4'b0100);
    bus.req = '0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < NCH; k++) exp_slot[k] = '0;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check_slots();
    repeat (20) begin
      @(negedge clk);
      check("no_done", bus.done, 0);
    end
    bus.bin_in = {12'd11, 12'd22, 12'd33, 12'd2468};
    bus.req = '1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.ack == '0 && n < 10);
    check("post_rst_grant", bus.ack, 4'b0001);
    bus.req = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.done && n < 40);
    check("post_rst_latency", n, 14);
    check("post_rst_ch", bus.done_ch, 0);
    exp_slot[0] = 16'h2468;
    check_slots();
    @(negedge clk);
    for (int t = 0; t < 1000; t++) begin
      int ch;
      logic [11:0] v;
      ch = int'($urandom_range(0, NCH - 1));
      v = 12'($urandom_range(0, 4095));
      convert(ch, v, ref_bcd(int'(v)), 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bcd_conv_sched.md
BCD_CONV_SCHED -- requirements
Module: bcd_conv_sched

Interface
REQ-001 Parameter: NCH, default 4, number of requesting channels (2..8).
REQ-002 Parameter: W, default 12, binary input width per channel (max value 4095 fits in 4 BCD digits).
REQ-003 Port: clk_100M  input  1  system clock; all logic on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: req  input  NCH  per-channel conversion request, level-sensitive.
REQ-006 Port: bin_in  input  NCH*W  channel k binary value at bits [k*W +: W].
REQ-007 Port: ack  output  NCH  one-cycle pulse marking the cycle in which channel k's bin_in is captured.
REQ-008 Port: busy  output  1  high from grant until the result is stored.
REQ-009 Port: done  output  1  one-cycle pulse when a result is written.
REQ-010 Port: done_ch  output  3  index of the channel whose result was written; valid with done.
REQ-011 Port: bcd_out  output  NCH*16  channel k result {qian,bai,shi,ge} at bits [k*16 +: 16]; held until the channel's next conversion completes.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, SHIFT and STORE.
REQ-013 IDLE: if any req bit is high, grant the first set bit at or after the round-robin pointer (wrapping), then go to LOAD; otherwise stay in IDLE.
REQ-014 LOAD: pulse ack[grant], capture bin_in[grant] into the shift register, clear the 16-bit BCD accumulator, clear the bit counter, go to SHIFT.
REQ-015 SHIFT (exactly W cycles): each cycle, first add 3 to every accumulator nibble greater than 4, then shift {accumulator, binary} left by one, moving the binary MSB into accumulator bit 0.
REQ-016 After the W-th shift: go to STORE.
REQ-017 STORE: write the accumulator to bcd_out slot grant, pulse done with done_ch = grant, set the pointer to grant+1 (modulo NCH), go to IDLE.
REQ-018 Latency SHALL be fixed: done is asserted W+2 cycles after the ack cycle.
REQ-019 Back-to-back throughput: one conversion per W+3 cycles, including 1 IDLE arbitration cycle.
REQ-020 busy SHALL be high in LOAD, SHIFT and STORE, and low in IDLE.
REQ-021 Changes to req or bin_in after the ack cycle SHALL NOT affect the conversion in progress.
REQ-022 A req dropped before grant is ignored; a requester that keeps req high is re-served after the other pending channels (round-robin fairness).
REQ-023 Simultaneous requests: with the pointer at 0, the lowest index wins.
REQ-024 No two channels SHALL ever be acked in the same cycle.
REQ-025 Arithmetic: each nibble correction is 4-bit, with no carry out of the nibble.
REQ-026 For inputs above 9999 (only possible if W > 13), qian is truncated; this case is not supported.

Reset
REQ-027 On rst high at a clock edge, the following SHALL be cleared: state to IDLE, pointer to 0, ack/busy/done/done_ch to 0, all bcd_out slots to 0, and the shift registers and counter.
REQ-028 rst asserted mid-conversion SHALL abort it: no done pulse and no bcd_out write.
REQ-029 rst SHALL take priority over all other inputs.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the BCD width constant (16), and the nibble-correction threshold (4) and offset (3).
REQ-031 Sub-module bcd_shift_core SHALL hold the accumulator, binary shift register and counter.
REQ-032 bcd_shift_core ports: load, bin, step, bcd, last.
REQ-033 The arbiter and FSM SHALL stay in the top level.

Verification
REQ-034 req=0001, ch0 bin=4095 -> ack[0] pulse, done 14 cycles later, done_ch=0, bcd_out slot0=16'h4095.
REQ-035 ch1 bin=0 -> slot1=16'h0000; ch2 bin=1234 -> slot2=16'h1234; ch3 bin=999 -> slot3=16'h0999.
REQ-036 req=1111 held, pointer=0 -> grant order 0,1,2,3,0, with done pulses 15 cycles apart.
REQ-037 bin_in changed the cycle after ack -> result reflects the captured value only.
REQ-038 rst during SHIFT cycle 5 -> no done pulse, all bcd_out=0, state IDLE, next grant is ch0.
REQ-039 Random 12-bit values on all channels over 1000 conversions -> every slot matches a reference decimal split.
